// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous RAM among NREQ requesters. Requests are
// served in round-robin order starting after the last requester that was
// actually granted. A three-state FSM (IDLE -> ISSUE -> [RDWAIT] -> IDLE)
// sequences the RAM port and returns read data one cycle after the read is
// issued.
//
// Ports
//   clk        : clock, all logic on rising edge
//   rst        : asynchronous, active-high reset
//   req        : per-requester request, held by the requester until gnt
//   we         : per-requester write enable (1 = write, 0 = read)
//   addr       : packed addresses, slice i = addr[i*AW +: AW]
//   wdata      : packed write data, slice i = wdata[i*DW +: DW]
//   gnt        : one-hot pulse, access of requester i issued to RAM
//   rvalid     : one-hot pulse, rdata holds the read result for requester i
//   rdata      : shared read data, zero whenever rvalid is zero
//   busy       : high whenever the FSM is not in IDLE
//   ram_en     : RAM port enable
//   ram_we     : RAM write enable
//   ram_addr   : RAM address
//   ram_wdata  : RAM write data
//   ram_rdata  : RAM read data, valid the cycle after a read is issued
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int NREQ = 4,
   parameter int AW   = 8,
   parameter int DW   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      we,
   input  logic [NREQ*AW-1:0]   addr,
   input  logic [NREQ*DW-1:0]   wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rvalid,
   output logic [DW-1:0]        rdata,
   output logic                 busy,
   output logic                 ram_en,
   output logic                 ram_we,
   output logic [AW-1:0]        ram_addr,
   output logic [DW-1:0]        ram_wdata,
   input  logic [DW-1:0]        ram_rdata
);

   localparam int PW = $clog2(NREQ);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ISSUE  = 2'd1,
      RDWAIT = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [PW-1:0]   r_sel;
   logic [PW-1:0]   w_selNext;
   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_ptrNext;
   logic [PW-1:0]   w_winner;
   logic            w_found;
   logic [AW-1:0]   w_addrArr  [NREQ];
   logic [DW-1:0]   w_wdataArr [NREQ];

   // Unpack the flat address/data buses so the selected slice is a plain
   // array lookup by the registered select.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         w_addrArr[i]  = addr[i*AW +: AW];
         w_wdataArr[i] = wdata[i*DW +: DW];
      end
   end

   // Round-robin search: scan ptr+1, ptr+2, ... wrapping, and take the first
   // active request. The last winner therefore has the lowest priority.
   always_comb begin
      logic [PW-1:0] v_idx;
      v_idx    = '0;
      w_winner = '0;
      w_found  = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         v_idx = PW'((int'(r_ptr) + k) % NREQ);
         if (!w_found && req[v_idx]) begin
            w_found  = 1'b1;
            w_winner = v_idx;
         end
      end
   end

   // State, select and last-winner pointer registers. Reset leaves the
   // pointer on the highest requester so requester 0 wins first.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_ptr   <= PW'(NREQ - 1);
      end else begin
         r_state <= w_stateNext;
         r_sel   <= w_selNext;
         r_ptr   <= w_ptrNext;
      end
   end

   // Next-state and output decode. RAM strobes come only from the registered
   // state/select; the requester's own req bit is still consulted in ISSUE so
   // a withdrawn request never reaches the RAM and never moves the pointer.
   always_comb begin
      w_stateNext = r_state;
      w_selNext   = r_sel;
      w_ptrNext   = r_ptr;
      gnt         = '0;
      rvalid      = '0;
      rdata       = '0;
      busy        = (r_state != IDLE);
      ram_en      = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_wdata   = '0;
      case (r_state)
         IDLE: begin
            if (w_found) begin
               w_selNext   = w_winner;
               w_stateNext = ISSUE;
            end
         end
         ISSUE: begin
            if (req[r_sel]) begin
               ram_en       = 1'b1;
               ram_we       = we[r_sel];
               ram_addr     = w_addrArr[r_sel];
               ram_wdata    = w_wdataArr[r_sel];
               gnt[r_sel]   = 1'b1;
               w_ptrNext    = r_sel;
               w_stateNext  = we[r_sel] ? IDLE : RDWAIT;
            end else begin
               w_stateNext  = IDLE;
            end
         end
         RDWAIT: begin
            rvalid[r_sel] = 1'b1;
            rdata         = ram_rdata;
            w_stateNext   = IDLE;
         end
         default: begin
            w_stateNext = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter with a behavioural 256x8 synchronous RAM
// attached to the RAM port. Inputs are driven on the falling edge (or just
// after a rising edge where a change inside a cycle is needed) and outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic                clk;
   logic                rst;
   logic [NREQ-1:0]     req;
   logic [NREQ-1:0]     we;
   logic [NREQ*AW-1:0]  addrBus;
   logic [NREQ*DW-1:0]  wdataBus;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rvalid;
   logic [DW-1:0]       rdata;
   logic                busy;
   logic                ramEn;
   logic                ramWe;
   logic [AW-1:0]       ramAddr;
   logic [DW-1:0]       ramWdata;
   logic [DW-1:0]       ramRdata;

   logic [DW-1:0]       mem [256];

   int checks   = 0;
   int failures = 0;

   mem_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr      (addrBus),
      .wdata     (wdataBus),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .busy      (busy),
      .ram_en    (ramEn),
      .ram_we    (ramWe),
      .ram_addr  (ramAddr),
      .ram_wdata (ramWdata),
      .ram_rdata (ramRdata)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural single-port RAM: write on enable+we, registered read data.
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      ramRdata = '0;
   end
   always @(posedge clk) begin
      if (ramEn) begin
         if (ramWe) mem[ramAddr] <= ramWdata;
         else       ramRdata     <= mem[ramAddr];
      end
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [NREQ-1:0] reqVec, input logic [NREQ-1:0] weVec);
      req = reqVec;
      we  = weVec;
   endtask

   task automatic setSlice(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
      addrBus[i*AW +: AW]  = a;
      wdataBus[i*DW +: DW] = d;
   endtask

   // Reset asserted on a falling edge, released on the next falling edge.
   task automatic doReset();
      rst = 1'b1;
      applyStimulus('0, '0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Independent round-robin choice used by the fairness run.
   function automatic int rrPick(input int p, input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   initial begin
      logic [NREQ-1:0] curReq;
      logic [NREQ-1:0] dropMask;
      int              expSel;
      int              expPtr;
      bit              expIssue;

      rst      = 1'b1;
      req      = '0;
      we       = '0;
      addrBus  = '0;
      wdataBus = '0;

      // Reset state
      @(negedge clk);
      checkOutput("rst_gnt",    32'(gnt),      32'h0);
      checkOutput("rst_rvalid", 32'(rvalid),   32'h0);
      checkOutput("rst_busy",   32'(busy),     32'h0);
      checkOutput("rst_ramen",  32'(ramEn),    32'h0);
      checkOutput("rst_ramwe",  32'(ramWe),    32'h0);
      checkOutput("rst_rdata",  32'(rdata),    32'h0);
      checkOutput("rst_raddr",  32'(ramAddr),  32'h0);
      checkOutput("rst_rwdata", 32'(ramWdata), 32'h0);
      rst = 1'b0;

      // 1: requester 0 writes 0xA5 to 0x10, then reads it back
      setSlice(0, 8'h10, 8'hA5);
      applyStimulus(4'b0001, 4'b0001);
      @(negedge clk);
      checkOutput("t1_wr_gnt",   32'(gnt),      32'h1);
      checkOutput("t1_wr_en",    32'(ramEn),    32'h1);
      checkOutput("t1_wr_we",    32'(ramWe),    32'h1);
      checkOutput("t1_wr_addr",  32'(ramAddr),  32'h10);
      checkOutput("t1_wr_data",  32'(ramWdata), 32'hA5);
      checkOutput("t1_wr_busy",  32'(busy),     32'h1);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t1_wr_idle",  32'(busy),     32'h0);
      checkOutput("t1_wr_nognt", 32'(gnt),      32'h0);
      @(negedge clk);
      applyStimulus(4'b0001, 4'b0000);
      @(negedge clk);
      checkOutput("t1_rd_gnt",   32'(gnt),      32'h1);
      checkOutput("t1_rd_en",    32'(ramEn),    32'h1);
      checkOutput("t1_rd_we",    32'(ramWe),    32'h0);
      checkOutput("t1_rd_nrv",   32'(rvalid),   32'h0);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t1_rd_rv",    32'(rvalid),   32'h1);
      checkOutput("t1_rd_data",  32'(rdata),    32'hA5);
      checkOutput("t1_rd_ngnt",  32'(gnt),      32'h0);
      @(negedge clk);
      checkOutput("t1_rd_rvoff", 32'(rvalid),   32'h0);
      checkOutput("t1_rd_dz",    32'(rdata),    32'h0);
      checkOutput("t1_rd_idle",  32'(busy),     32'h0);

      // 2: all four requesters hold write requests from reset
      doReset();
      for (int i = 0; i < NREQ; i++) setSlice(i, 8'(8'h20 + i), 8'(8'h50 + i));
      applyStimulus(4'b1111, 4'b1111);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t2_gnt%0d", k),  32'(gnt),      32'(1 << (k % NREQ)));
         checkOutput($sformatf("t2_addr%0d", k), 32'(ramAddr),  32'(8'h20 + (k % NREQ)));
         checkOutput($sformatf("t2_data%0d", k), 32'(ramWdata), 32'(8'h50 + (k % NREQ)));
         @(negedge clk);
         checkOutput($sformatf("t2_gap%0d", k),  32'(gnt),      32'h0);
      end
      applyStimulus(4'b0000, 4'b0000);

      // 3: last winner is 1; requesters 1 and 3 together -> 3 first, then 1
      @(negedge clk);
      applyStimulus(4'b1010, 4'b1010);
      @(negedge clk);
      checkOutput("t3_first",  32'(gnt), 32'h8);
      @(negedge clk);
      checkOutput("t3_gap",    32'(gnt), 32'h0);
      applyStimulus(4'b0010, 4'b1010);
      @(negedge clk);
      checkOutput("t3_second", 32'(gnt), 32'h2);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b1111);
      @(negedge clk);

      // 3b: random held write requests checked against a round-robin model
      curReq   = '0;
      dropMask = '0;
      expSel   = 0;
      expPtr   = 1;
      expIssue = 1'b0;
      for (int n = 0; n < 100; n++) begin
         checkOutput($sformatf("fair_gnt%0d", n), 32'(gnt), expIssue ? 32'(1 << expSel) : 32'h0);
         for (int i = 0; i < NREQ; i++) begin
            if (dropMask[i])                                 curReq[i] = 1'b0;
            else if (!curReq[i] && $urandom_range(0, 2) == 0) curReq[i] = 1'b1;
         end
         dropMask = expIssue ? NREQ'(1 << expSel) : '0;
         if (expIssue) begin
            expPtr   = expSel;
            expIssue = 1'b0;
         end else if (curReq != '0) begin
            expSel   = rrPick(expPtr, curReq);
            expIssue = 1'b1;
         end
         applyStimulus(curReq, 4'b1111);
         @(negedge clk);
      end

      // 4: requester 2 withdraws during ISSUE; pointer must stay on 3
      doReset();
      applyStimulus(4'b0100, 4'b0000);
      @(posedge clk);
      #1 applyStimulus(4'b0000, 4'b0000);
      @(negedge clk);
      checkOutput("t4_nognt", 32'(gnt),   32'h0);
      checkOutput("t4_noen",  32'(ramEn), 32'h0);
      checkOutput("t4_busy",  32'(busy),  32'h1);
      @(negedge clk);
      checkOutput("t4_idle",  32'(busy),  32'h0);
      checkOutput("t4_norv",  32'(rvalid), 32'h0);
      applyStimulus(4'b1111, 4'b1111);
      @(negedge clk);
      checkOutput("t4_ptr",   32'(gnt),   32'h1);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000);

      // 5: reset pulsed during RDWAIT
      setSlice(0, 8'h10, 8'h00);
      applyStimulus(4'b0001, 4'b0000);
      @(negedge clk);
      checkOutput("t5_gnt",    32'(gnt),    32'h1);
      @(posedge clk);
      #1 checkOutput("t5_rdwait", 32'(busy), 32'h1);
      rst = 1'b1;
      applyStimulus(4'b0000, 4'b0000);
      #1;
      checkOutput("t5_busy",   32'(busy),   32'h0);
      checkOutput("t5_ramen",  32'(ramEn),  32'h0);
      checkOutput("t5_rvalid", 32'(rvalid), 32'h0);
      checkOutput("t5_rdata",  32'(rdata),  32'h0);
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(4'b1010, 4'b1010);
      @(negedge clk);
      checkOutput("t5_after",  32'(gnt),    32'h2);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000);

      // 6: requester 0 writes 0x3C to 0x7F, requester 2 reads it back
      setSlice(0, 8'h7F, 8'h3C);
      setSlice(2, 8'h7F, 8'h00);
      applyStimulus(4'b0001, 4'b0001);
      @(negedge clk);
      checkOutput("t6_wgnt",  32'(gnt),      32'h1);
      checkOutput("t6_waddr", 32'(ramAddr),  32'h7F);
      checkOutput("t6_wdata", 32'(ramWdata), 32'h3C);
      checkOutput("t6_wwe",   32'(ramWe),    32'h1);
      @(negedge clk);
      checkOutput("t6_wnorv", 32'(rvalid),   32'h0);
      applyStimulus(4'b0100, 4'b0000);
      @(negedge clk);
      checkOutput("t6_rgnt",  32'(gnt),      32'h4);
      checkOutput("t6_rwe",   32'(ramWe),    32'h0);
      checkOutput("t6_raddr", 32'(ramAddr),  32'h7F);
      @(negedge clk);
      applyStimulus(4'b0000, 4'b0000);
      checkOutput("t6_rv",    32'(rvalid),   32'h4);
      checkOutput("t6_rdata", 32'(rdata),    32'h3C);
      @(negedge clk);
      checkOutput("t6_rvoff", 32'(rvalid),   32'h0);
      checkOutput("t6_idle",  32'(busy),     32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
